synchronization: RTL and testbench

SYNCHRONIZATION -- requirements
Module: synchronization

---
 rtl/synchronization.sv | 167 ++++++++++++++++
 tb/tb_synchronization.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/synchronization.sv
// 1000BASE-X PCS receive synchronization state machine: comma alignment, acquisition and loss of sync.
// Optional `define SYNC_FAST_ACQ_EN: declare sync after two commas instead of three.
module synchronization #(
    parameter int GOOD_CGS_LIMIT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       PUDI,
    input  logic [9:0] rx_code_group,
    output logic [9:0] x,
    output logic       rx_even,
    output logic       sync_status,
    output logic       SUDI
);

    typedef enum logic [3:0] {
        LOSS_OF_SYNC,
        COMMA_DETECT_1,
        ACQUIRE_SYNC_1,
        COMMA_DETECT_2,
`ifndef SYNC_FAST_ACQ_EN
        ACQUIRE_SYNC_2,
        COMMA_DETECT_3,
`endif
        SYNC_ACQUIRED_1,
        SYNC_ACQUIRED_2,
        SYNC_ACQUIRED_2A,
        SYNC_ACQUIRED_3,
        SYNC_ACQUIRED_3A,
        SYNC_ACQUIRED_4,
        SYNC_ACQUIRED_4A
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] good_cgs;
    logic [1:0] good_nxt;
    logic [1:0] good_inc;
    logic [3:0] ones;
    logic       long_run;
    logic       comma;
    logic       invalid;
    logic       cgbad;
    logic       data_ok;
    logic       aligned_comma;
    logic       limit_hit;

    function automatic logic is_synced(state_t s);
        return s inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3,
                         SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4, SYNC_ACQUIRED_4A};
    endfunction

    function automatic logic is_comma_detect(state_t s);
`ifdef SYNC_FAST_ACQ_EN
        return s inside {COMMA_DETECT_1, COMMA_DETECT_2};
`else
        return s inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3};
`endif
    endfunction

    // Disparity-free validity screen: ones count and run length over the whole 10-bit group.
    always_comb begin
        ones     = '0;
        long_run = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ones = ones + {3'b000, rx_code_group[i]};
        end
        for (int i = 0; i <= 4; i++) begin
            if ((&rx_code_group[i +: 6]) || (~|rx_code_group[i +: 6])) begin
                long_run = 1'b1;
            end
        end
    end

    assign comma         = (rx_code_group[9:3] == 7'b0011111) || (rx_code_group[9:3] == 7'b1100000);
    assign invalid       = (ones < 4'd4) || (ones > 4'd6) || long_run;
    assign cgbad         = invalid || (comma && rx_even);
    assign data_ok       = !comma && !invalid;
    assign aligned_comma = comma && !rx_even;
    assign good_inc      = (good_cgs == 2'd3) ? 2'd3 : good_cgs + 2'd1;
    assign limit_hit     = int'(good_inc) >= GOOD_CGS_LIMIT;

    // NOTE: every output of this block gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        good_nxt  = '0;
        case (state)
            LOSS_OF_SYNC:   if (comma) state_nxt = COMMA_DETECT_1;
            COMMA_DETECT_1: state_nxt = data_ok ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1: begin
                if (aligned_comma)  state_nxt = COMMA_DETECT_2;
                else if (cgbad)     state_nxt = LOSS_OF_SYNC;
            end
`ifdef SYNC_FAST_ACQ_EN
            COMMA_DETECT_2: state_nxt = data_ok ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
`else
            COMMA_DETECT_2: state_nxt = data_ok ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_2: begin
                if (aligned_comma)  state_nxt = COMMA_DETECT_3;
                else if (cgbad)     state_nxt = LOSS_OF_SYNC;
            end
            COMMA_DETECT_3: state_nxt = data_ok ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
`endif
            SYNC_ACQUIRED_1: if (cgbad) state_nxt = SYNC_ACQUIRED_2;
            SYNC_ACQUIRED_2: begin
                if (cgbad) state_nxt = SYNC_ACQUIRED_3;
                else begin
                    state_nxt = SYNC_ACQUIRED_2A;
                    good_nxt  = 2'd1;
                end
            end
            SYNC_ACQUIRED_3: begin
                if (cgbad) state_nxt = SYNC_ACQUIRED_4;
                else begin
                    state_nxt = SYNC_ACQUIRED_3A;
                    good_nxt  = 2'd1;
                end
            end
            SYNC_ACQUIRED_4: begin
                if (cgbad) state_nxt = LOSS_OF_SYNC;
                else begin
                    state_nxt = SYNC_ACQUIRED_4A;
                    good_nxt  = 2'd1;
                end
            end
            // Each A state steps back one level after GOOD_CGS_LIMIT consecutive good groups.
            SYNC_ACQUIRED_2A: begin
                if (cgbad)          state_nxt = SYNC_ACQUIRED_3;
                else if (limit_hit) state_nxt = SYNC_ACQUIRED_1;
                else                good_nxt  = good_inc;
            end
            SYNC_ACQUIRED_3A: begin
                if (cgbad)          state_nxt = SYNC_ACQUIRED_4;
                else if (limit_hit) state_nxt = SYNC_ACQUIRED_2;
                else                good_nxt  = good_inc;
            end
            SYNC_ACQUIRED_4A: begin
                if (cgbad)          state_nxt = LOSS_OF_SYNC;
                else if (limit_hit) state_nxt = SYNC_ACQUIRED_3;
                else                good_nxt  = good_inc;
            end
            default: state_nxt = LOSS_OF_SYNC;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= LOSS_OF_SYNC;
            good_cgs    <= '0;
            x           <= '0;
            rx_even     <= 1'b0;
            sync_status <= 1'b0;
            SUDI        <= 1'b0;
        end else begin
            SUDI <= PUDI;
            if (PUDI) begin
                state       <= state_nxt;
                good_cgs    <= good_nxt;
                x           <= rx_code_group;
                rx_even     <= is_comma_detect(state_nxt) ? 1'b1 : !rx_even;
                sync_status <= is_synced(state_nxt);
            end
        end
    end

endmodule

// File: tb/tb_synchronization.sv
// Self-checking bench for synchronization: directed scenarios plus a randomized code-group stream
// compared against a comma-counting / error-level model of the acquisition and sync rules.
module tb_synchronization;

    localparam int LIMIT = 3;
`ifdef SYNC_FAST_ACQ_EN
    localparam int NEED = 2;
`else
    localparam int NEED = 3;
`endif
    localparam logic [9:0] K28P  = 10'b0011111010;
    localparam logic [9:0] K28N  = 10'b1100000101;
    localparam logic [9:0] D16_2 = 10'b1001000101;
    localparam logic [9:0] BAD   = 10'b1111111111;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       PUDI = 1'b0;
    logic [9:0] rx_code_group = '0;
    logic [9:0] x;
    logic       rx_even;
    logic       sync_status;
    logic       SUDI;

    int checks = 0;
    int errors = 0;

    logic [9:0] data_tbl [4] = '{10'b1001000101, 10'b1010101010, 10'b1001110100, 10'b1010010110};
    logic [9:0] bad_tbl  [3] = '{10'b1111111111, 10'b0000000000, 10'b0000001111};

    // Reference model: acquisition counts aligned commas, sync tracks an error level 0..3 plus a good run.
    bit         m_synced;
    int         m_commas;
    bit         m_after;
    int         m_bad;
    int         m_good;
    bit         m_even;
    logic [9:0] m_x;
    bit         m_sudi;

    synchronization #(.GOOD_CGS_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst(rst),
        .PUDI(PUDI),
        .rx_code_group(rx_code_group),
        .x(x),
        .rx_even(rx_even),
        .sync_status(sync_status),
        .SUDI(SUDI)
    );

    always #5 clk = ~clk;

    function automatic bit m_is_comma(logic [9:0] cg);
        return (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);
    endfunction

    function automatic bit m_is_invalid(logic [9:0] cg);
        int   n_ones  = 0;
        int   run     = 0;
        int   longest = 0;
        logic prev    = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            n_ones += int'(cg[i]);
            if (i != 9 && cg[i] == prev) run++;
            else run = 1;
            if (run > longest) longest = run;
            prev = cg[i];
        end
        return (n_ones < 4) || (n_ones > 6) || (longest >= 6);
    endfunction

    function automatic logic [12:0] exp_vec();
        return {m_x, m_even, m_synced, m_sudi};
    endfunction

    task automatic model_reset();
        m_synced = 0; m_commas = 0; m_after = 0; m_bad = 0; m_good = 0;
        m_even = 0; m_x = '0; m_sudi = 0;
    endtask

    task automatic model_step(input bit pudi, input logic [9:0] cg);
        bit comma, inv, bad, even_pre;
        m_sudi = pudi;
        if (!pudi) return;
        comma    = m_is_comma(cg);
        inv      = m_is_invalid(cg);
        even_pre = m_even;
        bad      = inv || (comma && even_pre);
        m_x      = cg;
        if (m_synced) begin
            m_even = !m_even;
            if (bad) begin
                m_bad++;
                m_good = 0;
                if (m_bad == 4) begin
                    m_synced = 0; m_commas = 0; m_after = 0; m_bad = 0;
                end
            end else if (m_bad > 0) begin
                m_good = (m_good < 3) ? m_good + 1 : 3;
                if (m_good >= LIMIT) begin
                    m_bad--;
                    m_good = 0;
                end
            end
        end else if (m_commas == 0) begin
            if (comma) begin
                m_commas = 1; m_after = 1; m_even = 1;
            end else m_even = !m_even;
        end else if (m_after) begin
            m_even  = !m_even;
            m_after = 0;
            if (!comma && !inv) begin
                if (m_commas == NEED) begin
                    m_synced = 1; m_bad = 0; m_good = 0;
                end
            end else m_commas = 0;
        end else begin
            if (comma && !even_pre) begin
                m_commas++; m_after = 1; m_even = 1;
            end else begin
                m_even = !m_even;
                if (bad) m_commas = 0;
            end
        end
    endtask

    task automatic drive(input bit pudi, input logic [9:0] cg);
        PUDI          = pudi;
        rx_code_group = cg;
        @(posedge clk);
        #1;
        model_step(pudi, cg);
    endtask

    task automatic apply_reset();
        rst           = 1'b0;
        PUDI          = 1'b1;
        rx_code_group = K28P;
        @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic sync_up();
        apply_reset();
        for (int i = 0; i < 2 * NEED; i++) drive(1'b1, (i % 2 == 0) ? K28P : D16_2);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            rst           = 1'b0;
            PUDI          = 1'($urandom_range(0, 1));
            rx_code_group = 10'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({x, rx_even, sync_status, SUDI} !== 13'd0) begin
                errors++;
                $display("FAIL reset_%0d: got %h expected %h", i, {x, rx_even, sync_status, SUDI}, 13'd0);
            end
        end
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_acquire();
        apply_reset();
        for (int i = 0; i < 2 * NEED + 2; i++) begin
            drive(1'b1, (i % 2 == 0) ? K28P : D16_2);
            checks++;
            if ({x, rx_even, sync_status, SUDI} !== exp_vec()) begin
                errors++;
                $display("FAIL acquire_%0d: got %h expected %h", i, {x, rx_even, sync_status, SUDI}, exp_vec());
            end
            checks++;
            if (sync_status !== (i >= 2 * NEED - 1)) begin
                errors++;
                $display("FAIL acquire_sync_%0d: got %b expected %b", i, sync_status, (i >= 2 * NEED - 1));
            end
        end
    endtask

    task automatic test_pudi_hold();
        apply_reset();
        drive(1'b1, K28P);
        drive(1'b1, D16_2);
        drive(1'b1, K28P);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 10'($urandom));
            checks++;
            if ({x, rx_even, sync_status, SUDI} !== {K28P, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL pudi_hold_%0d: got %h expected %h", i, {x, rx_even, sync_status, SUDI},
                         {K28P, 1'b1, 1'b0, 1'b0});
            end
        end
        for (int i = 3; i < 2 * NEED; i++) begin
            drive(1'b1, (i % 2 == 0) ? K28P : D16_2);
            checks++;
            if ({x, rx_even, sync_status, SUDI} !== exp_vec()) begin
                errors++;
                $display("FAIL pudi_resume_%0d: got %h expected %h", i, {x, rx_even, sync_status, SUDI}, exp_vec());
            end
        end
        checks++;
        if (sync_status !== 1'b1) begin
            errors++;
            $display("FAIL pudi_resume_sync: got %b expected 1", sync_status);
        end
    endtask

    task automatic test_bad_recover();
        logic [9:0] seq [8] = '{BAD, D16_2, K28P, D16_2, BAD, BAD, BAD, BAD};
        sync_up();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, seq[i]);
            checks++;
            if ({x, rx_even, sync_status, SUDI} !== exp_vec()) begin
                errors++;
                $display("FAIL recover_%0d: got %h expected %h", i, {x, rx_even, sync_status, SUDI}, exp_vec());
            end
            checks++;
            if (sync_status !== (i < 7)) begin
                errors++;
                $display("FAIL recover_sync_%0d: got %b expected %b", i, sync_status, (i < 7));
            end
        end
    endtask

    task automatic test_loss();
        sync_up();
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 3; j++) begin
                drive(1'b1, (j == 0) ? bad_tbl[$urandom_range(0, 2)] : data_tbl[$urandom_range(0, 3)]);
                checks++;
                if (sync_status !== (r < 3)) begin
                    errors++;
                    $display("FAIL loss_%0d_%0d: got %b expected %b", r, j, sync_status, (r < 3));
                end
                checks++;
                if ({x, rx_even, sync_status, SUDI} !== exp_vec()) begin
                    errors++;
                    $display("FAIL loss_model_%0d_%0d: got %h expected %h", r, j,
                             {x, rx_even, sync_status, SUDI}, exp_vec());
                end
            end
        end
    endtask

    task automatic test_odd_comma();
        logic [9:0] seq [4] = '{K28P, D16_2, D16_2, K28P};
        apply_reset();
        foreach (seq[i]) drive(1'b1, seq[i]);
        checks++;
        if ({x, rx_even, sync_status, SUDI} !== {K28P, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL odd_comma: got %h expected %h", {x, rx_even, sync_status, SUDI},
                     {K28P, 1'b0, 1'b0, 1'b1});
        end
        for (int i = 0; i < 2 * NEED; i++) begin
            drive(1'b1, (i % 2 == 0) ? K28N : D16_2);
            checks++;
            if ({x, rx_even, sync_status, SUDI} !== exp_vec()) begin
                errors++;
                $display("FAIL odd_comma_reacq_%0d: got %h expected %h", i, {x, rx_even, sync_status, SUDI},
                         exp_vec());
            end
        end
    endtask

    task automatic test_reset_synced();
        sync_up();
        checks++;
        if (sync_status !== 1'b1) begin
            errors++;
            $display("FAIL reset_synced_pre: got %b expected 1", sync_status);
        end
        apply_reset();
        checks++;
        if ({x, rx_even, sync_status, SUDI} !== 13'd0) begin
            errors++;
            $display("FAIL reset_synced: got %h expected %h", {x, rx_even, sync_status, SUDI}, 13'd0);
        end
    endtask

    task automatic test_random();
        bit         phase = 0;
        bit         pudi;
        int         k;
        logic [9:0] cg;
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                apply_reset();
                phase = 0;
            end
            pudi = ($urandom_range(0, 99) < 85);
            cg   = 10'($urandom);
            if (pudi) begin
                k = $urandom_range(0, 99);
                if (k < 6) begin
                    cg = bad_tbl[$urandom_range(0, 2)];
                    phase = !phase;
                end else if (k < 9) begin
                    phase = !phase;
                end else if (k < 12) begin
                    cg = data_tbl[$urandom_range(0, 3)];
                end else begin
                    cg = phase ? data_tbl[$urandom_range(0, 3)] : ($urandom_range(0, 1) ? K28P : K28N);
                    phase = !phase;
                end
            end
            drive(pudi, cg);
            checks++;
            if ({x, rx_even, sync_status, SUDI} !== exp_vec()) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h", n, {x, rx_even, sync_status, SUDI}, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_acquire();
        test_pudi_hold();
        test_bad_recover();
        test_loss();
        test_odd_comma();
        test_reset_synced();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
